// File: rtl/iir_coef_loader.sv
// ---------------------------------------------------------------------------
// iir_coef_loader
//
// Configuration front end for iir_core. Coefficient frames arrive on an
// AXI-stream slave, are collected word by word in a shadow bank, and are
// copied to the active bank (coefs) in a single clock edge while iir_core
// reports it is idle. A filter pass therefore never sees a mix of old and
// new coefficients. Frames of the wrong length are dropped and flagged.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   s_axis_tdata   coefficient word; word k of a frame lands in coefs[k]
//   s_axis_tvalid  word valid
//   s_axis_tready  loader can take a word (low while a frame waits to commit)
//   s_axis_tlast   last word of the frame
//   commit_ok      iir_core idle; a pending frame may be committed
//   coefs          active coefficient bank, N words, feeds iir_core
//   coef_update    one-cycle pulse: coefs changed on this cycle's rising edge
//   frame_err      one-cycle pulse: a malformed frame was dropped
// ---------------------------------------------------------------------------
module iir_coef_loader #(
    parameter int COEFW = 18,
    parameter int COEFQ = 16,
    parameter int ORDER = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [COEFW-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    commit_ok,
    output logic signed [COEFW-1:0] coefs [(ORDER+1)*2],
    output logic                    coef_update,
    output logic                    frame_err
);

    localparam int N  = (ORDER + 1) * 2;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0]          LAST_IDX = CW'(N - 1);
    // 1.0 in the coefficient fixed-point format: coefs[0] = 1.0 is a pass-through filter.
    localparam logic signed [COEFW-1:0] UNITY   = COEFW'(1) << COEFQ;

    localparam logic [1:0] LOAD    = 2'd0;
    localparam logic [1:0] DISCARD = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;

    logic [1:0]              state;
    logic [CW-1:0]           cnt;
    logic signed [COEFW-1:0] shadow [N];
    logic                    accept;

    // Gated with rst so that a word offered during reset is never handshaken.
    assign s_axis_tready = !rst && (state != PENDING);
    assign accept        = s_axis_tvalid && s_axis_tready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            cnt         <= '0;
            coef_update <= 1'b0;
            frame_err   <= 1'b0;
            // NOTE: the shadow bank is reset as well, so a commit can never
            // expose uninitialised storage; it costs only a reset fan-out.
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
                coefs[i]  <= (i == 0) ? UNITY : '0;
            end
        end else begin
            // NOTE: pulse outputs default low every cycle; the branches below
            // raise them only on the one cycle they apply.
            coef_update <= 1'b0;
            frame_err   <= 1'b0;

            case (state)
                LOAD: begin
                    if (accept) begin
                        shadow[cnt] <= s_axis_tdata;
                        if (s_axis_tlast) begin
                            cnt <= '0;
                            if (cnt == LAST_IDX) begin
                                state <= PENDING;
                            end else begin
                                // Short frame: the partial shadow contents are
                                // simply overwritten by the next frame.
                                frame_err <= 1'b1;
                            end
                        end else if (cnt == LAST_IDX) begin
                            // Long frame: swallow the rest up to tlast.
                            cnt   <= '0;
                            state <= DISCARD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                DISCARD: begin
                    if (accept && s_axis_tlast) begin
                        frame_err <= 1'b1;
                        state     <= LOAD;
                    end
                end

                PENDING: begin
                    if (commit_ok) begin
                        for (int i = 0; i < N; i++) begin
                            coefs[i] <= shadow[i];
                        end
                        coef_update <= 1'b1;
                        state       <= LOAD;
                    end
                end

                default: begin
                    state <= LOAD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_coef_loader.sv
// ---------------------------------------------------------------------------
// tb_iir_coef_loader
//
// Self-checking bench for iir_coef_loader. The reference model is the frame
// rule itself: a frame of exactly N words becomes the new coefficient bank
// once commit_ok is seen; any other length is dropped with one frame_err.
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_iir_coef_loader;

    localparam int COEFW = 18;
    localparam int COEFQ = 16;
    localparam int ORDER = 2;
    localparam int N     = (ORDER + 1) * 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic signed [COEFW-1:0] tdata = '0;
    logic                    tvalid = 1'b0;
    logic                    tready;
    logic                    tlast = 1'b0;
    logic                    commit_ok = 1'b0;
    logic signed [COEFW-1:0] coefs [N];
    logic                    coef_update;
    logic                    frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters: every high cycle of each pulse output, seen at the falling edge.
    int err_pulses = 0;
    int upd_pulses = 0;

    // Model state: the bank the DUT should currently be driving.
    logic signed [COEFW-1:0] exp_coefs [N];
    logic signed [COEFW-1:0] frame_buf [16];

    always #5 clk = ~clk;

    iir_coef_loader #(
        .COEFW(COEFW),
        .COEFQ(COEFQ),
        .ORDER(ORDER)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .s_axis_tlast (tlast),
        .commit_ok    (commit_ok),
        .coefs        (coefs),
        .coef_update  (coef_update),
        .frame_err    (frame_err)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err === 1'b1)   err_pulses++;
            if (coef_update === 1'b1) upd_pulses++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- utilities ----------------
    function automatic logic [N*COEFW-1:0] flat_act();
        logic [N*COEFW-1:0] f;
        for (int i = 0; i < N; i++) f[i*COEFW +: COEFW] = coefs[i];
        return f;
    endfunction

    function automatic logic [N*COEFW-1:0] flat_exp();
        logic [N*COEFW-1:0] f;
        for (int i = 0; i < N; i++) f[i*COEFW +: COEFW] = exp_coefs[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_passthrough();
        for (int i = 0; i < N; i++) exp_coefs[i] = (i == 0) ? COEFW'(1 << COEFQ) : '0;
    endtask

    task automatic adopt_frame();
        for (int i = 0; i < N; i++) exp_coefs[i] = frame_buf[i];
    endtask

    task automatic fill_random(input int len);
        for (int k = 0; k < len; k++) frame_buf[k] = COEFW'($urandom);
    endtask

    // Drives len words of frame_buf; returns at 1 unit after the edge that
    // accepted the final word. Each word must be taken within 50 cycles.
    task automatic send_words(input int len, input bit with_last, output bit ok);
        int waited;
        ok = 1'b1;
        for (int k = 0; k < len; k++) begin
            tdata  = frame_buf[k];
            tlast  = with_last && (k == len - 1);
            tvalid = 1'b1;
            waited = 0;
            while (tready !== 1'b1 && waited < 50) begin
                tick();
                waited++;
            end
            n_checks++;
            if (tready !== 1'b1) begin
                n_fail++;
                $display("FAIL word_accept: word %0d not accepted, tready=%b after %0d cycles, required 1", k, tready, waited);
                ok     = 1'b0;
                tvalid = 1'b0;
                tlast  = 1'b0;
                return;
            end
            tick();
            if (k < len - 1 && $urandom_range(0, 3) == 0) begin
                tvalid = 1'b0;
                tdata  = COEFW'($urandom);
                repeat ($urandom_range(1, 2)) tick();
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tvalid = 1'b1;
        tdata = 18'sd123;
        commit_ok = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tready: got %b, required 0", tready);
        end
        rst = 1'b0;
        tvalid = 1'b0;
        set_passthrough();
        n_checks++;
        if (flat_act() !== flat_exp()) begin
            n_fail++;
            $display("FAIL reset_coefs: got %h, required %h", flat_act(), flat_exp());
        end
        tick();
        n_checks++;
        if (tready !== 1'b1 || coef_update !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: tready=%b coef_update=%b frame_err=%b, required 1 0 0", tready, coef_update, frame_err);
        end
        n_checks++;
        if (coefs[0] !== 18'sd65536) begin
            n_fail++;
            $display("FAIL reset_unity: coefs[0]=%0d, required 65536", coefs[0]);
        end
    endtask

    task automatic test_commit();
        bit ok;
        int u0 = upd_pulses;
        int e0 = err_pulses;
        frame_buf[0] = 18'sd100;  frame_buf[1] = 18'sd200; frame_buf[2] = 18'sd300;
        frame_buf[3] = 18'sd0;    frame_buf[4] = -18'sd400; frame_buf[5] = 18'sd500;
        commit_ok = 1'b1;
        send_words(N, 1'b1, ok);
        n_checks++;
        if (tready !== 1'b0 || coef_update !== 1'b0 || flat_act() !== flat_exp()) begin
            n_fail++;
            $display("FAIL commit_pending: tready=%b coef_update=%b coefs=%h, required 0 0 %h", tready, coef_update, flat_act(), flat_exp());
        end
        tick();
        adopt_frame();
        n_checks++;
        if (coef_update !== 1'b1 || flat_act() !== flat_exp()) begin
            n_fail++;
            $display("FAIL commit_update: coef_update=%b coefs=%h, required 1 %h", coef_update, flat_act(), flat_exp());
        end
        n_checks++;
        if (tready !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_tready_back: got %b, required 1", tready);
        end
        tick();
        tick();
        n_checks++;
        if (upd_pulses - u0 != 1 || err_pulses - e0 != 0) begin
            n_fail++;
            $display("FAIL commit_pulses: update=%0d err=%0d, required 1 0", upd_pulses - u0, err_pulses - e0);
        end
    endtask

    task automatic test_commit_stall();
        bit ok;
        int bad = 0;
        int u0 = upd_pulses;
        for (int k = 0; k < N; k++) frame_buf[k] = -exp_coefs[k] + 18'sd7;
        commit_ok = 1'b0;
        send_words(N, 1'b1, ok);
        for (int c = 0; c < 20; c++) begin
            if (tready !== 1'b0 || coef_update !== 1'b0 || flat_act() !== flat_exp()) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d of 20 cycles wrong (tready=%b coefs=%h), required 0 wrong", bad, tready, flat_act());
        end
        commit_ok = 1'b1;
        tick();
        adopt_frame();
        n_checks++;
        if (coef_update !== 1'b1 || flat_act() !== flat_exp()) begin
            n_fail++;
            $display("FAIL stall_commit: coef_update=%b coefs=%h, required 1 %h", coef_update, flat_act(), flat_exp());
        end
        tick();
        n_checks++;
        if (upd_pulses - u0 != 1) begin
            n_fail++;
            $display("FAIL stall_pulses: update=%0d, required 1", upd_pulses - u0);
        end
    endtask

    task automatic test_bad_length(input int len);
        bit ok;
        int u0 = upd_pulses;
        int e0 = err_pulses;
        commit_ok = 1'b1;
        fill_random(len);
        send_words(len, 1'b1, ok);
        n_checks++;
        if (frame_err !== 1'b1 || err_pulses != e0 || coef_update !== 1'b0 || tready !== 1'b1) begin
            n_fail++;
            $display("FAIL badlen%0d_err: frame_err=%b early_err=%0d coef_update=%b tready=%b, required 1 0 0 1", len, frame_err, err_pulses - e0, coef_update, tready);
        end
        tick();
        n_checks++;
        if (frame_err !== 1'b0 || flat_act() !== flat_exp()) begin
            n_fail++;
            $display("FAIL badlen%0d_hold: frame_err=%b coefs=%h, required 0 %h", len, frame_err, flat_act(), flat_exp());
        end
        fill_random(N);
        send_words(N, 1'b1, ok);
        tick();
        adopt_frame();
        n_checks++;
        if (coef_update !== 1'b1 || flat_act() !== flat_exp()) begin
            n_fail++;
            $display("FAIL badlen%0d_recover: coef_update=%b coefs=%h, required 1 %h", len, coef_update, flat_act(), flat_exp());
        end
        tick();
        n_checks++;
        if (upd_pulses - u0 != 1 || err_pulses - e0 != 1) begin
            n_fail++;
            $display("FAIL badlen%0d_pulses: update=%0d err=%0d, required 1 1", len, upd_pulses - u0, err_pulses - e0);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        fill_random(N);
        commit_ok = 1'b1;
        send_words(3, 1'b0, ok);
        rst = 1'b1;
        #1;
        set_passthrough();
        n_checks++;
        if (flat_act() !== flat_exp() || tready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_coefs: coefs=%h tready=%b, required %h 0", flat_act(), tready, flat_exp());
        end
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < N; k++) frame_buf[k] = COEFW'((k + 1) * 7);
        send_words(N, 1'b1, ok);
        tick();
        adopt_frame();
        n_checks++;
        if (coef_update !== 1'b1 || flat_act() !== flat_exp() || coefs[0] !== 18'sd7) begin
            n_fail++;
            $display("FAIL midrst_recover: coef_update=%b coefs=%h, required 1 %h", coef_update, flat_act(), flat_exp());
        end
        tick();
    endtask

    task automatic test_random();
        bit ok;
        int len, stall, u0, e0, bad;
        for (int it = 0; it < 30; it++) begin
            len   = ($urandom_range(0, 1) == 0) ? N : $urandom_range(1, 10);
            stall = $urandom_range(0, 3);
            commit_ok = (stall == 0);
            u0 = upd_pulses;
            e0 = err_pulses;
            fill_random(len);
            send_words(len, 1'b1, ok);
            if (len == N) begin
                bad = 0;
                for (int c = 0; c < stall; c++) begin
                    if (tready !== 1'b0 || flat_act() !== flat_exp()) bad++;
                    tick();
                end
                commit_ok = 1'b1;
                n_checks++;
                if (bad != 0 || tready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand%0d_wait: %0d bad cycles, tready=%b, required 0 bad and 0", it, bad, tready);
                end
                tick();
                adopt_frame();
                n_checks++;
                if (coef_update !== 1'b1 || flat_act() !== flat_exp()) begin
                    n_fail++;
                    $display("FAIL rand%0d_commit: coef_update=%b coefs=%h, required 1 %h", it, coef_update, flat_act(), flat_exp());
                end
            end else begin
                n_checks++;
                if (frame_err !== 1'b1 || flat_act() !== flat_exp()) begin
                    n_fail++;
                    $display("FAIL rand%0d_drop: len=%0d frame_err=%b coefs=%h, required 1 %h", it, len, frame_err, flat_act(), flat_exp());
                end
            end
            tick();
            n_checks++;
            if (upd_pulses - u0 != ((len == N) ? 1 : 0) || err_pulses - e0 != ((len == N) ? 0 : 1)) begin
                n_fail++;
                $display("FAIL rand%0d_pulses: len=%0d update=%0d err=%0d", it, len, upd_pulses - u0, err_pulses - e0);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_commit();
        test_commit_stall();
        test_bad_length(4);
        test_bad_length(9);
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
